// File: rtl/zjh_vote_ctrl.sv
// -----------------------------------------------------------------------------
// zjh_vote_ctrl
//   Sequencer for a three-judge 2-of-3 majority voter. A round opens on start.
//   The block then collects one vote per judge, computes the majority decision
//   and the yes-count, and presents the result for HOLD_CYC cycles. It also
//   keeps wrapping counters of completed and passed rounds.
//
// Parameters
//   CNT_W        width of round_cnt / pass_cnt
//   HOLD_CYC     cycles result_vld stays high (>= 1)
//   TIMEOUT_CYC  COLLECT cycle limit (>= 2), used only with VOTE_TIMEOUT_EN
//
// Optional feature
//   VOTE_TIMEOUT_EN  when defined, a COLLECT timer closes a round that has not
//                    received all votes after TIMEOUT_CYC cycles. Judges that
//                    have not voted count as no. When undefined, COLLECT waits
//                    indefinitely and timeout is tied low.
//
// Ports
//   clk         in   system clock, rising edge
//   rst         in   asynchronous reset, active-high
//   start       in   open a round (sampled only in IDLE)
//   vote_vld    in   [2:0] per-judge vote strobe
//   vote_yes    in   [2:0] per-judge vote value, qualified by vote_vld
//   busy        out  round in progress (COLLECT/DECIDE/SHOW)
//   voted       out  [2:0] judges whose vote is latched this round
//   result_vld  out  result window active
//   pass        out  majority decision of the last completed round
//   tally       out  [1:0] yes votes of the last completed round
//   timeout     out  last round closed by timeout
//   round_cnt   out  [CNT_W-1:0] completed rounds (wrapping)
//   pass_cnt    out  [CNT_W-1:0] passed rounds (wrapping)
// -----------------------------------------------------------------------------
module zjh_vote_ctrl #(
  parameter int CNT_W       = 8,
  parameter int HOLD_CYC    = 4,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       vote_vld,
  input  logic [2:0]       vote_yes,
  output logic             busy,
  output logic [2:0]       voted,
  output logic             result_vld,
  output logic             pass,
  output logic [1:0]       tally,
  output logic             timeout,
  output logic [CNT_W-1:0] round_cnt,
  output logic [CNT_W-1:0] pass_cnt
);

  localparam int HOLD_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DECIDE  = 2'd2,
    ST_SHOW    = 2'd3
  } state_t;

  // Reject illegal parameterisations at elaboration time.
  if (HOLD_CYC < 1 || TIMEOUT_CYC < 2) begin : g_param_err
    $error("zjh_vote_ctrl: HOLD_CYC must be >= 1 and TIMEOUT_CYC >= 2");
  end

  // 2-of-3 majority of the latched yes bits.
  function automatic logic majority3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

  // Number of yes bits (0..3).
  function automatic logic [1:0] yes_count(input logic [2:0] v);
    return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
  endfunction

  state_t            state_r;
  logic [2:0]        yes_r;
  logic [HOLD_W-1:0] hold_r;

  // Only judges that have not voted yet may latch a value: first vote wins.
  logic [2:0] new_votes_s;
  logic [2:0] voted_nxt_s;
  logic [2:0] yes_nxt_s;

  assign new_votes_s = vote_vld & ~voted;
  assign voted_nxt_s = voted | new_votes_s;
  assign yes_nxt_s   = (yes_r & ~new_votes_s) | (vote_yes & new_votes_s);

`ifdef VOTE_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT_CYC);

  logic [TMR_W-1:0] timer_r;
  logic             timed_out_r;
`else
  assign timeout = 1'b0;
`endif

  // Round sequencer: state, latched votes, result and statistics registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      yes_r      <= 3'b000;
      hold_r     <= '0;
      busy       <= 1'b0;
      voted      <= 3'b000;
      result_vld <= 1'b0;
      pass       <= 1'b0;
      tally      <= 2'd0;
      round_cnt  <= '0;
      pass_cnt   <= '0;
`ifdef VOTE_TIMEOUT_EN
      timer_r     <= '0;
      timed_out_r <= 1'b0;
      timeout     <= 1'b0;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            // Open a fresh round; previous votes must never leak into it.
            state_r <= ST_COLLECT;
            busy    <= 1'b1;
            voted   <= 3'b000;
            yes_r   <= 3'b000;
`ifdef VOTE_TIMEOUT_EN
            timer_r     <= '0;
            timed_out_r <= 1'b0;
`endif
          end else begin
            state_r <= ST_IDLE;
          end
        end

        ST_COLLECT: begin
          voted <= voted_nxt_s;
          yes_r <= yes_nxt_s;
          // A completing vote wins over a timer expiring in the same cycle.
          if (voted_nxt_s == 3'b111) begin
            state_r <= ST_DECIDE;
`ifdef VOTE_TIMEOUT_EN
            timed_out_r <= 1'b0;
          end else if (timer_r == TMR_W'(TIMEOUT_CYC - 1)) begin
            state_r     <= ST_DECIDE;
            timed_out_r <= 1'b1;
          end else begin
            state_r <= ST_COLLECT;
            timer_r <= timer_r + TMR_W'(1);
          end
`else
          end else begin
            state_r <= ST_COLLECT;
          end
`endif
        end

        ST_DECIDE: begin
          pass       <= majority3(yes_r);
          tally      <= yes_count(yes_r);
          round_cnt  <= round_cnt + CNT_W'(1);
          pass_cnt   <= pass_cnt + CNT_W'(majority3(yes_r));
          hold_r     <= '0;
          result_vld <= 1'b1;
          state_r    <= ST_SHOW;
`ifdef VOTE_TIMEOUT_EN
          timeout <= timed_out_r;
`endif
        end

        ST_SHOW: begin
          // start is not looked at here: no queuing of a new round.
          if (hold_r == HOLD_W'(HOLD_CYC - 1)) begin
            state_r    <= ST_IDLE;
            result_vld <= 1'b0;
            busy       <= 1'b0;
          end else begin
            hold_r <= hold_r + HOLD_W'(1);
          end
        end

        default: begin
          state_r    <= ST_IDLE;
          busy       <= 1'b0;
          result_vld <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_zjh_vote_ctrl.sv
// -----------------------------------------------------------------------------
// tb_zjh_vote_ctrl
//   Table-driven bench for zjh_vote_ctrl. Each table record describes one round
//   (up to three vote cycles) with its hand-computed decision and yes-count.
//   Hand-written sequences cover reset mid-round, the COLLECT timeout (or the
//   indefinite wait in the default build) and counter wrap on a CNT_W=2 copy.
// -----------------------------------------------------------------------------
module tb_zjh_vote_ctrl;

  localparam int HOLD = 4;

  logic       clk;
  logic       rst;
  logic       start;
  logic [2:0] vote_vld;
  logic [2:0] vote_yes;

  logic       busy;
  logic [2:0] voted;
  logic       result_vld;
  logic       pass;
  logic [1:0] tally;
  logic       timeout;
  logic [7:0] round_cnt;
  logic [7:0] pass_cnt;

  logic       b_busy;
  logic [2:0] b_voted;
  logic       b_result_vld;
  logic       b_pass;
  logic [1:0] b_tally;
  logic       b_timeout;
  logic [1:0] b_round_cnt;
  logic [1:0] b_pass_cnt;

  int compared;
  int mismatched;
  int exp_rounds;
  int exp_passes;

  typedef struct {
    int         nsteps;
    logic [8:0] vld;        // step s in bits [3*s +: 3]
    logic [8:0] yes;
    logic       exp_pass;
    logic [1:0] exp_tally;
    logic       start_show; // hold start high through the result window
  } vec_t;

  vec_t tbl [6];

  zjh_vote_ctrl #(.CNT_W(8), .HOLD_CYC(HOLD), .TIMEOUT_CYC(8)) u_dut (
    .clk(clk), .rst(rst), .start(start), .vote_vld(vote_vld), .vote_yes(vote_yes),
    .busy(busy), .voted(voted), .result_vld(result_vld), .pass(pass), .tally(tally),
    .timeout(timeout), .round_cnt(round_cnt), .pass_cnt(pass_cnt)
  );

  zjh_vote_ctrl #(.CNT_W(2), .HOLD_CYC(HOLD), .TIMEOUT_CYC(8)) u_dut_w2 (
    .clk(clk), .rst(rst), .start(start), .vote_vld(vote_vld), .vote_yes(vote_yes),
    .busy(b_busy), .voted(b_voted), .result_vld(b_result_vld), .pass(b_pass),
    .tally(b_tally), .timeout(b_timeout), .round_cnt(b_round_cnt), .pass_cnt(b_pass_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_counters();
    check("round_cnt", 32'(round_cnt), 32'(exp_rounds));
    check("pass_cnt", 32'(pass_cnt), 32'(exp_passes));
    check("w2_round_cnt", 32'(b_round_cnt), 32'(exp_rounds % 4));
    check("w2_pass_cnt", 32'(b_pass_cnt), 32'(exp_passes % 4));
  endtask

  task automatic run_round(input vec_t v);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("open_busy", 32'(busy), 32'd1);
    check("open_voted", 32'(voted), 32'd0);
    for (int s = 0; s < v.nsteps; s++) begin
      vote_vld = v.vld[3*s +: 3];
      vote_yes = v.yes[3*s +: 3];
      tick();
    end
    vote_vld = 3'b000;
    vote_yes = 3'b000;
    // DECIDE cycle: all voted, result not yet shown.
    check("decide_voted", 32'(voted), 32'h7);
    check("decide_rvld", 32'(result_vld), 32'd0);
    exp_rounds = exp_rounds + 1;
    exp_passes = exp_passes + 32'(v.exp_pass);
    for (int h = 0; h < HOLD; h++) begin
      start = v.start_show;
      tick();
      check("show_rvld", 32'(result_vld), 32'd1);
      check("show_busy", 32'(busy), 32'd1);
      check("pass", 32'(pass), 32'(v.exp_pass));
      check("tally", 32'(tally), 32'(v.exp_tally));
      check("timeout", 32'(timeout), 32'd0);
      check_counters();
    end
    tick();
    start = 1'b0;
    check("end_rvld", 32'(result_vld), 32'd0);
    check("end_busy", 32'(busy), 32'd0);
    tick();
    check("idle_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    exp_rounds = 0;
    exp_passes = 0;
    rst      = 1'b1;
    start    = 1'b0;
    vote_vld = 3'b000;
    vote_yes = 3'b000;

    // Round table: vld/yes steps listed last-step first in the concatenation.
    tbl[0] = '{3, {3'b100, 3'b010, 3'b001}, {3'b000, 3'b010, 3'b001}, 1'b1, 2'd2, 1'b0};
    tbl[1] = '{1, {3'b000, 3'b000, 3'b111}, {3'b000, 3'b000, 3'b001}, 1'b0, 2'd1, 1'b0};
    tbl[2] = '{3, {3'b110, 3'b001, 3'b001}, {3'b000, 3'b000, 3'b001}, 1'b0, 2'd1, 1'b1};
    tbl[3] = '{2, {3'b000, 3'b100, 3'b011}, {3'b000, 3'b100, 3'b011}, 1'b1, 2'd3, 1'b0};
    tbl[4] = '{1, {3'b000, 3'b000, 3'b111}, {3'b000, 3'b000, 3'b000}, 1'b0, 2'd0, 1'b0};
    tbl[5] = '{3, {3'b011, 3'b100, 3'b000}, {3'b010, 3'b100, 3'b111}, 1'b1, 2'd2, 1'b1};

    // Reset state.
    tick();
    tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rvld", 32'(result_vld), 32'd0);
    check("rst_voted", 32'(voted), 32'd0);
    check_counters();
    rst = 1'b0;
    tick();

    // Reset pulse mid-COLLECT with two judges voted.
    start = 1'b1;
    tick();
    start    = 1'b0;
    vote_vld = 3'b011;
    vote_yes = 3'b011;
    tick();
    vote_vld = 3'b000;
    vote_yes = 3'b000;
    check("mid_voted", 32'(voted), 32'h3);
    #2;
    rst = 1'b1;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_voted", 32'(voted), 32'd0);
    check("arst_pass", 32'(pass), 32'd0);
    check("arst_tally", 32'(tally), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    check("post_rst_idle", 32'(busy), 32'd0);

    // Table-driven rounds.
    for (int i = 0; i < 6; i++) begin
      run_round(tbl[i]);
    end

    // Only judges 1 and 2 vote yes; judge 0 stays silent.
    start = 1'b1;
    tick();
    start    = 1'b0;
    vote_vld = 3'b110;
    vote_yes = 3'b110;
    tick();
    vote_vld = 3'b000;
    vote_yes = 3'b000;
    for (int k = 0; k < 6; k++) begin
      tick();
    end
    check("to_wait_busy", 32'(busy), 32'd1);
    check("to_wait_voted", 32'(voted), 32'h6);
`ifdef VOTE_TIMEOUT_EN
    tick();
    check("to_decide_rvld", 32'(result_vld), 32'd0);
    tick();
    exp_rounds = exp_rounds + 1;
    exp_passes = exp_passes + 1;
    check("to_rvld", 32'(result_vld), 32'd1);
    check("to_pass", 32'(pass), 32'd1);
    check("to_tally", 32'(tally), 32'd2);
    check("to_voted", 32'(voted), 32'h6);
    check("to_flag", 32'(timeout), 32'd1);
    check_counters();
`else
    for (int k = 0; k < 14; k++) begin
      tick();
    end
    check("no_to_busy", 32'(busy), 32'd1);
    check("no_to_rvld", 32'(result_vld), 32'd0);
    check("no_to_flag", 32'(timeout), 32'd0);
    vote_vld = 3'b001;
    vote_yes = 3'b000;
    tick();
    vote_vld = 3'b000;
    tick();
    exp_rounds = exp_rounds + 1;
    exp_passes = exp_passes + 1;
    check("late_rvld", 32'(result_vld), 32'd1);
    check("late_pass", 32'(pass), 32'd1);
    check("late_tally", 32'(tally), 32'd2);
    check_counters();
`endif
    for (int k = 0; k < HOLD; k++) begin
      tick();
    end
    check("to_end_busy", 32'(busy), 32'd0);

    // Counter wrap: fresh reset, four passing rounds -> CNT_W=2 copy goes 1,2,3,0.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_rounds = 0;
    exp_passes = 0;
    tick();
    for (int r = 0; r < 4; r++) begin
      run_round('{1, {3'b000, 3'b000, 3'b111}, {3'b000, 3'b000, 3'b111}, 1'b1, 2'd3, 1'b0});
    end
    check("wrap_w2_round", 32'(b_round_cnt), 32'd0);
    check("wrap_w8_round", 32'(round_cnt), 32'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
